// File: rtl/psum_loopback_buf_pkg.sv
// Shared definitions for the partial-sum loopback buffer.
//   buf_state_t : controller state (IDLE / PASS / DRAIN)
//   acc_width   : accumulator width derived from the operand width
//   lane_lsb    : bit offset of a lane inside a packed multi-lane word
package psum_loopback_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } buf_state_t;

  function automatic int acc_width(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int lane_lsb(input int lane, input int acc_w);
    return lane * acc_w;
  endfunction

endpackage

// File: rtl/psum_deskew_mux.sv
// Combinational de-skew selector for the drain path.
// Builds one output row: lane c is taken from stored word row+c, lane c,
// undoing the one-cycle-per-column skew of the PE array.
//   row      in   RW              output row index m
//   mem      in   DEPTH x COLS*ACC_W  stored skewed words
//   row_data out  COLS*ACC_W      de-skewed row
module psum_deskew_mux
  import psum_loopback_buf_pkg::*;
#(
  parameter int COLS  = 8,
  parameter int DEPTH = 64,
  parameter int ACC_W = 16,
  localparam int RW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int WW   = COLS * ACC_W
)(
  input  logic [RW-1:0] row,
  input  logic [WW-1:0] mem [DEPTH],
  output logic [WW-1:0] row_data
);

  // Lanes whose source word would fall past the array read as zero; a legal
  // tile never reaches them because n_words <= DEPTH.
  always_comb begin
    row_data = '0;
    for (int c = 0; c < COLS; c++) begin
      if ((int'(row) + c) < DEPTH) begin
        row_data[lane_lsb(c, ACC_W) +: ACC_W] =
          mem[RW'(int'(row) + c)][lane_lsb(c, ACC_W) +: ACC_W];
      end
    end
  end

endmodule

// File: rtl/psum_loopback_buf.sv
// Partial-sum loopback buffer for a weight-stationary PE array with K tiling.
// A first pass captures skewed C_out words, later passes replay them on C_acc
// while overwriting them with new sums, and a last pass is followed by a drain
// of de-skewed rows, one row per valid/ready handshake.
//   clk, rst        clock and synchronous active-high reset
//   cmd_start/first/last/m   pass command (sampled only in IDLE)
//   psum_valid/psum_in       PE array output words to store
//   acc_req/acc_out          replay of stored words to the PE array
//   drain_ready/valid/data/row  de-skewed result rows
//   busy, pass_done, cmd_err, ovf_err, udf_err   status
module psum_loopback_buf
  import psum_loopback_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 8,
  parameter int DEPTH      = 64,
  localparam int ACC_W     = acc_width(DATA_WIDTH),
  localparam int MW        = $clog2(DEPTH + 1),
  localparam int RW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int WW        = COLS * ACC_W
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_start,
  input  logic          cmd_first,
  input  logic          cmd_last,
  input  logic [MW-1:0] cmd_m,
  input  logic          psum_valid,
  input  logic [WW-1:0] psum_in,
  input  logic          acc_req,
  output logic [WW-1:0] acc_out,
  input  logic          drain_ready,
  output logic          drain_valid,
  output logic [WW-1:0] drain_data,
  output logic [RW-1:0] drain_row,
  output logic          busy,
  output logic          pass_done,
  output logic          cmd_err,
  output logic          ovf_err,
  output logic          udf_err
);

  localparam int CW = MW + $clog2(COLS) + 1;

  buf_state_t    state_q, state_d;
  logic [WW-1:0] mem [DEPTH];
  logic [MW-1:0] wr_ptr_q, rd_ptr_q, n_words_q, m_q;
  logic          first_q, last_q;
  logic          drain_valid_q;
  logic [WW-1:0] drain_data_q;
  logic [RW-1:0] drain_row_q;
  logic          pass_done_q, cmd_err_q, ovf_q, udf_q;

  logic [CW-1:0] n_calc;
  logic          start_ok, start_bad, wr_en, last_write, drain_hs, drain_last;
  logic [MW-1:0] m_minus1;
  logic [RW-1:0] last_row, sel_row;
  logic [WW-1:0] deskew_row;

  // Word count for a new tile: M rows plus the COLS-1 words of column skew.
  assign n_calc     = CW'(cmd_m) + CW'(COLS - 1);
  assign wr_en      = (state_q == ST_PASS) && psum_valid && (wr_ptr_q < n_words_q);
  assign last_write = wr_en && ((wr_ptr_q + MW'(1)) == n_words_q);
  assign m_minus1   = m_q - MW'(1);
  assign last_row   = m_minus1[RW-1:0];
  assign drain_hs   = (state_q == ST_DRAIN) && drain_valid_q && drain_ready;
  assign drain_last = drain_hs && (drain_row_q == last_row);
  // Row 0 is loaded on the first DRAIN cycle, then each handshake loads the next.
  assign sel_row    = drain_valid_q ? (drain_row_q + RW'(1)) : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and command acceptance.
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          if (cmd_first ? ((cmd_m == '0) || (n_calc > CW'(DEPTH))) : (n_words_q == '0)) begin
            start_bad = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = ST_PASS;
          end
        end
      end
      ST_PASS:  if (last_write) state_d = last_q ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (drain_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[RW-1:0]] <= psum_in;
  end

  // Pointers, tile bookkeeping and status flags. A start overrides the
  // per-cycle updates; a first-pass start also clears the sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      n_words_q   <= '0;
      m_q         <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      pass_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      pass_done_q <= last_write;
      cmd_err_q   <= start_bad;
      if (wr_en) wr_ptr_q <= wr_ptr_q + MW'(1);
      if (psum_valid && !wr_en) ovf_q <= 1'b1;
      if (acc_req) begin
        if (rd_ptr_q < n_words_q) rd_ptr_q <= rd_ptr_q + MW'(1);
        else                      udf_q    <= 1'b1;
      end
      if (start_ok) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        first_q  <= cmd_first;
        last_q   <= cmd_last;
        if (cmd_first) begin
          n_words_q <= n_calc[MW-1:0];
          m_q       <= cmd_m;
          ovf_q     <= 1'b0;
          udf_q     <= 1'b0;
        end
      end
    end
  end

  // Drain output register: holds its row until the handshake completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_valid_q <= 1'b0;
      drain_data_q  <= '0;
      drain_row_q   <= '0;
    end else if (state_q == ST_DRAIN) begin
      if (!drain_valid_q || (drain_hs && !drain_last)) begin
        drain_valid_q <= 1'b1;
        drain_data_q  <= deskew_row;
        drain_row_q   <= sel_row;
      end else if (drain_last) begin
        drain_valid_q <= 1'b0;
      end
    end
  end

  psum_deskew_mux #(
    .COLS  (COLS),
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) u_deskew (
    .row      (sel_row),
    .mem      (mem),
    .row_data (deskew_row)
  );

  assign acc_out     = ((state_q == ST_PASS) && !first_q && (rd_ptr_q < n_words_q))
                       ? mem[rd_ptr_q[RW-1:0]] : '0;
  assign busy        = (state_q != ST_IDLE);
  assign pass_done   = pass_done_q;
  assign cmd_err     = cmd_err_q;
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;
  assign drain_valid = drain_valid_q;
  assign drain_data  = drain_data_q;
  assign drain_row   = drain_row_q;

endmodule

// File: tb/tb_psum_loopback_buf.sv
// Self-checking bench for psum_loopback_buf (COLS=8, DEPTH=64, ACC_W=16).
// A reference array holds what each stored word should be; replay and drain
// expectations are derived from it using the buffer's documented rules.
module tb_psum_loopback_buf;

  localparam int COLS = 8;
  localparam int DEPTH = 64;
  localparam int ACC_W = 16;
  localparam int WW = COLS * ACC_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_start = 1'b0, cmd_first = 1'b0, cmd_last = 1'b0;
  logic [6:0]    cmd_m = '0;
  logic          psum_valid = 1'b0;
  logic [WW-1:0] psum_in = '0;
  logic          acc_req = 1'b0;
  logic [WW-1:0] acc_out;
  logic          drain_ready = 1'b0;
  logic          drain_valid;
  logic [WW-1:0] drain_data;
  logic [5:0]    drain_row;
  logic          busy, pass_done, cmd_err, ovf_err, udf_err;

  int total = 0;
  int bad = 0;
  logic [WW-1:0] ref_mem [DEPTH];

  psum_loopback_buf #(.DATA_WIDTH(8), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_first(cmd_first), .cmd_last(cmd_last), .cmd_m(cmd_m),
    .psum_valid(psum_valid), .psum_in(psum_in),
    .acc_req(acc_req), .acc_out(acc_out),
    .drain_ready(drain_ready), .drain_valid(drain_valid),
    .drain_data(drain_data), .drain_row(drain_row),
    .busy(busy), .pass_done(pass_done), .cmd_err(cmd_err),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  // Word i lane c = i*16 + c
  function automatic logic [WW-1:0] pat_word(input int i);
    logic [WW-1:0] w;
    for (int c = 0; c < COLS; c++) w[c*ACC_W +: ACC_W] = 16'(i * 16 + c);
    return w;
  endfunction

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int c = 0; c < COLS; c++) w[c*ACC_W +: ACC_W] = 16'($urandom);
    return w;
  endfunction

  // Output row m, lane c comes from stored word m+c, lane c.
  function automatic logic [WW-1:0] exp_row(input int m);
    logic [WW-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*ACC_W +: ACC_W] = ref_mem[m + c][c*ACC_W +: ACC_W];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_cmd(input bit first, input bit last, input int m);
    cmd_start = 1'b1;
    cmd_first = first;
    cmd_last  = last;
    cmd_m     = 7'(m);
    tick();
    cmd_start = 1'b0;
    cmd_first = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One cycle of array traffic; returns acc_out as seen before the edge.
  task automatic pass_cycle(input logic [WW-1:0] w, input bit req, input bit vld,
                            output logic [WW-1:0] seen);
    psum_valid = vld;
    psum_in    = w;
    acc_req    = req;
    #1;
    seen = acc_out;
    tick();
    psum_valid = 1'b0;
    acc_req    = 1'b0;
  endtask

  task automatic test_reset();
    logic [WW-1:0] seen;
    bit saw_done;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    total++; if ({pass_done, cmd_err, ovf_err, udf_err, drain_valid} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b exp=00000", {pass_done, cmd_err, ovf_err, udf_err, drain_valid}); end
    total++; if (acc_out !== '0 || drain_data !== '0 || drain_row !== '0) begin
      bad++; $display("[TB] FAIL reset_data acc=%0h drain=%0h row=%0d exp=0", acc_out, drain_data, drain_row); end
    start_cmd(1'b1, 1'b0, 8);
    for (int i = 0; i < 5; i++) pass_cycle(pat_word(i), 1'b1, 1'b1, seen);
    pulse_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midpass_reset_busy got=%0b exp=0", busy); end
    saw_done = pass_done;
    repeat (12) begin tick(); saw_done |= pass_done; end
    total++; if (saw_done !== 1'b0) begin bad++; $display("[TB] FAIL midpass_reset_done got=1 exp=0"); end
  endtask

  task automatic test_first_pass();
    logic [WW-1:0] seen;
    int nz = 0;
    start_cmd(1'b1, 1'b0, 8);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL first_busy got=%0b exp=1", busy); end
    for (int i = 0; i < 15; i++) begin
      pass_cycle(pat_word(i), 1'b1, 1'b1, seen);
      if (seen !== '0) nz++;
      ref_mem[i] = pat_word(i);
    end
    total++; if (nz != 0) begin bad++; $display("[TB] FAIL first_acc_zero got=%0d nonzero exp=0", nz); end
    total++; if (pass_done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL first_done got done=%0b busy=%0b exp done=1 busy=0", pass_done, busy); end
    tick();
    total++; if (pass_done !== 1'b0 || ovf_err !== 1'b0 || udf_err !== 1'b0) begin
      bad++; $display("[TB] FAIL first_after got done=%0b ovf=%0b udf=%0b exp 000", pass_done, ovf_err, udf_err); end
  endtask

  task automatic test_replay();
    logic [WW-1:0] seen, w;
    int i = 0;
    start_cmd(1'b0, 1'b0, 0);
    for (int k = 0; k < 200 && i < 15; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        pass_cycle('0, 1'b0, 1'b0, seen);
        total++; if (seen !== ref_mem[i]) begin bad++; $display("[TB] FAIL replay_hold%0d got=%0h exp=%0h", i, seen, ref_mem[i]); end
      end else begin
        w = rand_word();
        pass_cycle(w, 1'b1, 1'b1, seen);
        total++; if (seen !== ref_mem[i]) begin bad++; $display("[TB] FAIL replay_word%0d got=%0h exp=%0h", i, seen, ref_mem[i]); end
        ref_mem[i] = w;
        i++;
      end
    end
    total++; if (i != 15 || pass_done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL replay_done got words=%0d done=%0b busy=%0b exp 15/1/0", i, pass_done, busy); end
  endtask

  task automatic test_drain();
    logic [WW-1:0] seen;
    int exp_r = 0;
    int cyc = 0;
    bit rdy = 1'b1;
    start_cmd(1'b0, 1'b1, 0);
    for (int i = 0; i < 15; i++) begin
      pass_cycle(pat_word(i), 1'b1, 1'b1, seen);
      total++; if (seen !== ref_mem[i]) begin bad++; $display("[TB] FAIL last_replay%0d got=%0h exp=%0h", i, seen, ref_mem[i]); end
      ref_mem[i] = pat_word(i);
    end
    total++; if (pass_done !== 1'b1 || busy !== 1'b1 || drain_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL drain_entry got done=%0b busy=%0b valid=%0b exp 1/1/0", pass_done, busy, drain_valid); end
    tick();
    total++; if (drain_valid !== 1'b1) begin bad++; $display("[TB] FAIL drain_rise got=%0b exp=1", drain_valid); end
    while (exp_r < 8 && cyc < 100) begin
      drain_ready = rdy;
      #1;
      total++;
      if (drain_valid !== 1'b1 || drain_row !== 6'(exp_r) || drain_data !== exp_row(exp_r)) begin
        bad++; $display("[TB] FAIL drain_row%0d got v=%0b r=%0d d=%0h exp v=1 r=%0d d=%0h",
                        exp_r, drain_valid, drain_row, drain_data, exp_r, exp_row(exp_r));
      end
      tick();
      if (rdy) exp_r++;
      rdy = !rdy;
      cyc++;
    end
    drain_ready = 1'b0;
    total++; if (exp_r != 8 || busy !== 1'b0 || drain_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL drain_end got rows=%0d busy=%0b valid=%0b exp 8/0/0", exp_r, busy, drain_valid); end
  endtask

  task automatic test_cmd_err();
    pulse_reset();
    start_cmd(1'b0, 1'b0, 0);
    total++; if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL err_nofirst got err=%0b busy=%0b exp 1/0", cmd_err, busy); end
    tick();
    total++; if (cmd_err !== 1'b0) begin bad++; $display("[TB] FAIL err_pulse got=%0b exp=0", cmd_err); end
    start_cmd(1'b1, 1'b0, 60);
    total++; if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL err_depth got err=%0b busy=%0b exp 1/0", cmd_err, busy); end
    start_cmd(1'b1, 1'b0, 0);
    total++; if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL err_m0 got err=%0b busy=%0b exp 1/0", cmd_err, busy); end
    start_cmd(1'b1, 1'b0, 57);
    total++; if (cmd_err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL err_fullfit got err=%0b busy=%0b exp 0/1", cmd_err, busy); end
    pulse_reset();
  endtask

  task automatic test_overflow();
    logic [WW-1:0] seen, w;
    start_cmd(1'b1, 1'b0, 8);
    for (int i = 0; i < 16; i++) begin
      w = rand_word();
      pass_cycle(w, 1'b1, 1'b1, seen);
      if (i < 15) ref_mem[i] = w;
    end
    total++; if (ovf_err !== 1'b1 || udf_err !== 1'b1) begin
      bad++; $display("[TB] FAIL ovf_udf_set got ovf=%0b udf=%0b exp 1/1", ovf_err, udf_err); end
    repeat (3) tick();
    start_cmd(1'b0, 1'b0, 0);
    for (int i = 0; i < 15; i++) begin
      w = rand_word();
      pass_cycle(w, 1'b1, 1'b1, seen);
      total++; if (seen !== ref_mem[i]) begin bad++; $display("[TB] FAIL ovf_replay%0d got=%0h exp=%0h", i, seen, ref_mem[i]); end
      ref_mem[i] = w;
    end
    total++; if (ovf_err !== 1'b1 || udf_err !== 1'b1) begin
      bad++; $display("[TB] FAIL ovf_udf_sticky got ovf=%0b udf=%0b exp 1/1", ovf_err, udf_err); end
    start_cmd(1'b1, 1'b0, 8);
    total++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin
      bad++; $display("[TB] FAIL ovf_udf_clear got ovf=%0b udf=%0b exp 0/0", ovf_err, udf_err); end
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_first_pass();
    test_replay();
    test_drain();
    test_cmd_err();
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
